// File: rtl/dmem_resp_pkg.sv
// Shared size codes and FSM encoding for
// the data-memory responder.
package dmem_resp_pkg;

  localparam logic [1:0] SWHB_WORD = 2'b01;
  localparam logic [1:0] SWHB_HALF = 2'b10;
  localparam logic [1:0] SWHB_BYTE = 2'b11;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'b00,
    DMR_WAIT = 2'b01,
    DMR_RESP = 2'b10
  } dmr_state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a word
// and extends it to 32 bits.
module load_align
  import dmem_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  swhb,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    unique case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_lo[1] ? word[31:16]
                          : word[15:0];
  end

  always_comb begin
    result = '0;
    unique case (swhb)
      SWHB_WORD: result = word;
      SWHB_HALF: result = uns
        ? {16'h0, half_sel}
        : {{16{half_sel[15]}}, half_sel};
      SWHB_BYTE: result = uns
        ? {24'h0, byte_sel}
        : {{24{byte_sel[7]}}, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder
// with byte-enable stores and extended loads.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_amp,
  input  logic [1:0]  req_swhb,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  dmr_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lo;
  logic [3:0]    amp_exp;
  logic          range_err;
  logic          size_err;
  logic          align_err;
  logic          amp_err;
  logic          err;
  logic          accept;
  logic [31:0]   rd_word;
  logic [31:0]   ld_val;

  assign off = req_addr - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign lo  = off[1:0];

  // wrap below BASE_ADDR lands in the high bits too
  assign range_err = |off[31:AW+2];
  assign size_err  = (req_swhb == 2'b00);

  always_comb begin
    amp_exp = '0;
    unique case (req_swhb)
      SWHB_WORD: amp_exp = 4'b1111;
      SWHB_HALF: amp_exp = lo[1] ? 4'b1100
                                 : 4'b0011;
      SWHB_BYTE: amp_exp = 4'b0001 << lo;
      default:   amp_exp = '0;
    endcase
  end

  assign align_err =
    ((req_swhb == SWHB_HALF) && lo[0]) ||
    ((req_swhb == SWHB_WORD) && (lo != 2'b00));
  assign amp_err = req_we && (req_amp != amp_exp);
  assign err = range_err | size_err |
               align_err | amp_err;

  assign accept = (state_q == DMR_IDLE) &&
                  req_valid;

  assign rd_word = mem[idx];

  load_align u_align (
    .word    (rd_word),
    .addr_lo (lo),
    .swhb    (req_swhb),
    .uns     (req_unsigned),
    .result  (ld_val)
  );

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_amp[i])
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      DMR_IDLE: begin
        if (req_valid) begin
          err_d   = err;
          rdata_d = (req_we || err) ? '0 : ld_val;
          if (LATENCY == 1) begin
            state_d = DMR_RESP;
          end else begin
            state_d = DMR_WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      DMR_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = DMR_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DMR_RESP: begin
        if (resp_ready)
          state_d = DMR_IDLE;
      end
      default: state_d = DMR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMR_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == DMR_IDLE);
  assign resp_valid = (state_q == DMR_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two latencies side by side
// against a byte-array reference model.
module tb_dmem_resp;

  localparam int          D    = 64;
  localparam logic [31:0] BASE = 32'h80000000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_amp;
  logic [1:0]  req_swhb;
  logic        req_unsigned;
  logic        resp_ready;

  logic        rr1, rv1, re1;
  logic [31:0] rd1;
  logic        rr3, rv3, re3;
  logic [31:0] rd3;

  int checks;
  int errors;

  logic [7:0] mm [4*D];

  dmem_resp #(
    .DEPTH_WORDS (D),
    .LATENCY     (1),
    .BASE_ADDR   (BASE)
  ) u_l1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (rr1),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_amp      (req_amp),
    .req_swhb     (req_swhb),
    .req_unsigned (req_unsigned),
    .resp_valid   (rv1),
    .resp_ready   (resp_ready),
    .resp_rdata   (rd1),
    .resp_err     (re1)
  );

  dmem_resp #(
    .DEPTH_WORDS (D),
    .LATENCY     (3),
    .BASE_ADDR   (BASE)
  ) u_l3 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (rr3),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_amp      (req_amp),
    .req_swhb     (req_swhb),
    .req_unsigned (req_unsigned),
    .resp_valid   (rv3),
    .resp_ready   (resp_ready),
    .resp_rdata   (rd3),
    .resp_err     (re3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] s);
    case (s)
      2'b01:   return 4;
      2'b10:   return 2;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] pat_of(
      input logic [1:0] s, input logic [31:0] a);
    int n;
    n = size_of(s);
    if (n == 0) return 4'b0000;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  task automatic model(input logic we,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [3:0] amp,
                       input logic [1:0] swhb,
                       input logic uns,
                       output logic [31:0] erd,
                       output logic eerr);
    int n;
    int lo;
    longint off;
    longint v;
    n    = size_of(swhb);
    lo   = int'(addr % 4);
    off  = longint'({32'h0, addr}) -
           longint'({32'h0, BASE});
    eerr = 1'b0;
    erd  = '0;
    if (n == 0) eerr = 1'b1;
    else if (addr % n != 0) eerr = 1'b1;
    if (off < 0 || off >= 4 * D) eerr = 1'b1;
    if (we && amp != pat_of(swhb, addr)) eerr = 1'b1;
    if (eerr) return;
    if (we) begin
      for (int b = 0; b < n; b++)
        mm[int'(off) + b] = wdata[8*(lo+b) +: 8];
    end else begin
      v = 0;
      for (int b = 0; b < n; b++)
        v = v | (longint'(mm[int'(off) + b]) << (8*b));
      if (!uns && ((v >> (8*n - 1)) & 1) == 1)
        v = v - (longint'(1) << (8*n));
      erd = 32'(v);
    end
  endtask

  task automatic xact(input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [3:0] amp,
                      input logic [1:0] swhb,
                      input logic uns,
                      input int hold);
    logic [31:0] erd;
    logic        eerr;
    int          l1;
    int          l3;
    model(we, addr, wdata, amp, swhb, uns, erd, eerr);
    chk("req_ready1_idle", 32'(rr1), 32'd1);
    chk("req_ready3_idle", 32'(rr3), 32'd1);
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_amp      = amp;
    req_swhb     = swhb;
    req_unsigned = uns;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    l1 = -1;
    l3 = -1;
    for (int k = 0; k < 8; k++) begin
      if (l1 < 0 && rv1) l1 = k;
      if (l3 < 0 && rv3) l3 = k;
      if (l1 >= 0 && l3 >= 0) break;
      @(posedge clk);
      #1;
    end
    chk("latency1", 32'(l1), 32'd0);
    chk("latency3", 32'(l3), 32'd2);
    for (int h = 0; h <= hold; h++) begin
      chk("rdata1", rd1, erd);
      chk("err1", 32'(re1), 32'(eerr));
      chk("rdata3", rd3, erd);
      chk("err3", 32'(re3), 32'(eerr));
      chk("req_ready3_busy", 32'(rr3), 32'd0);
      chk("resp_valid3_hold", 32'(rv3), 32'd1);
      if (h < hold) begin
        @(posedge clk);
        #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("resp_valid1_done", 32'(rv1), 32'd0);
    chk("resp_valid3_done", 32'(rv3), 32'd0);
    chk("req_ready1_done", 32'(rr1), 32'd1);
    chk("req_ready3_done", 32'(rr3), 32'd1);
  endtask

  task automatic reset_in_wait;
    logic [31:0] erd;
    logic        eerr;
    model(1'b1, BASE + 32'h40, 32'h12345678,
          4'b1111, 2'b01, 1'b0, erd, eerr);
    req_we       = 1'b1;
    req_addr     = BASE + 32'h40;
    req_wdata    = 32'h12345678;
    req_amp      = 4'b1111;
    req_swhb     = 2'b01;
    req_unsigned = 1'b0;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_resp_valid1", 32'(rv1), 32'd0);
    chk("rst_resp_valid3", 32'(rv3), 32'd0);
    chk("rst_req_ready1", 32'(rr1), 32'd1);
    chk("rst_req_ready3", 32'(rr3), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    xact(1'b0, BASE + 32'h40, 32'h0, 4'h0,
         2'b01, 1'b0, 0);
  endtask

  initial begin
    logic        we;
    logic [31:0] addr;
    logic [3:0]  amp;
    logic [1:0]  swhb;
    int          r;
    int          n;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_amp      = '0;
    req_swhb     = '0;
    req_unsigned = 1'b0;
    resp_ready   = 1'b0;
    #1;
    chk("reset_req_ready1", 32'(rr1), 32'd1);
    chk("reset_resp_valid1", 32'(rv1), 32'd0);
    chk("reset_rdata1", rd1, 32'h0);
    chk("reset_err1", 32'(re1), 32'd0);
    chk("reset_req_ready3", 32'(rr3), 32'd1);
    chk("reset_resp_valid3", 32'(rv3), 32'd0);
    chk("reset_rdata3", rd3, 32'h0);
    chk("reset_err3", 32'(re3), 32'd0);
    #20;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int w = 0; w < D; w++)
      xact(1'b1, BASE + 32'(4*w), $urandom,
           4'b1111, 2'b01, 1'b0, 0);

    xact(1, BASE+32'h10, 32'hDEADBEEF, 4'b1111, 2'b01, 0, 0);
    xact(0, BASE+32'h10, 32'h0, 4'h0, 2'b01, 0, 0);
    xact(1, BASE+32'h12, 32'h00AA0000, 4'b0100, 2'b11, 0, 0);
    xact(0, BASE+32'h10, 32'h0, 4'h0, 2'b01, 0, 0);
    xact(0, BASE+32'h12, 32'h0, 4'h0, 2'b11, 0, 0);
    xact(0, BASE+32'h12, 32'h0, 4'h0, 2'b11, 1, 0);
    xact(0, BASE+32'h12, 32'h0, 4'h0, 2'b10, 0, 0);
    xact(0, BASE+32'h11, 32'h0, 4'h0, 2'b10, 0, 0);
    xact(1, BASE+32'h12, 32'h11111111, 4'b1111, 2'b01, 0, 0);
    xact(0, BASE+32'h10, 32'h0, 4'h0, 2'b01, 0, 0);
    xact(1, BASE+32'h10, 32'h22222222, 4'b1100, 2'b10, 0, 0);
    xact(0, BASE+32'h10, 32'h0, 4'h0, 2'b01, 0, 5);
    xact(0, 32'h7FFFFFFC, 32'h0, 4'h0, 2'b01, 0, 0);
    xact(0, BASE+32'(4*D), 32'h0, 4'h0, 2'b01, 0, 5);
    xact(0, BASE+32'h10, 32'h0, 4'h0, 2'b00, 0, 0);

    reset_in_wait();

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      swhb = (r == 0) ? 2'b00 : 2'((r % 3) + 1);
      r = $urandom_range(0, 9);
      if (r == 0)
        addr = BASE - 32'(4 * $urandom_range(1, 4));
      else if (r == 1)
        addr = BASE + 32'(4*D + $urandom_range(0, 15));
      else
        addr = BASE + 32'($urandom_range(0, 4*D - 1));
      n = size_of(swhb);
      if (r >= 2 && n > 0 && $urandom_range(0, 3) != 0)
        addr = addr - (addr % n);
      amp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        amp = pat_of(swhb, addr);
      xact(we, addr, $urandom, amp, swhb,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
